// File: rtl/pipe_control_decode_if.sv
// Decoder handshake and control-bundle bus.
// Upstream drives instr/valid/stall/flush; decoder returns stage controls.
interface pipe_control_decode_if #(
   parameter int INSTR_W   = 32,
   parameter int RF_ADDR_W = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic [INSTR_W-1:0]   instr;
   logic                 stall_ext;
   logic                 flush;
   logic                 ex_valid;
   logic                 ex_regWrite;
   logic                 ex_branch;
   logic                 ex_opB;
   logic                 ex_store;
   logic                 ex_memToReg;
   logic [2:0]           ex_immSel;
   logic [1:0]           ex_opA;
   logic [1:0]           ex_nextPc;
   logic [2:0]           ex_alu;
   logic [3:0]           ex_aluSel;
   logic [RF_ADDR_W-1:0] ex_rd;
   logic                 ex_illegal;
   logic                 wb_valid;
   logic                 wb_regWrite;
   logic                 wb_memToReg;
   logic [RF_ADDR_W-1:0] wb_rd;
   logic                 hazard_stall;

   modport master (
      output in_valid, instr, stall_ext, flush,
      input  in_ready, ex_valid, ex_regWrite, ex_branch, ex_opB,
      input  ex_store, ex_memToReg, ex_immSel, ex_opA, ex_nextPc,
      input  ex_alu, ex_aluSel, ex_rd, ex_illegal,
      input  wb_valid, wb_regWrite, wb_memToReg, wb_rd, hazard_stall
   );

   modport slave (
      input  in_valid, instr, stall_ext, flush,
      output in_ready, ex_valid, ex_regWrite, ex_branch, ex_opB,
      output ex_store, ex_memToReg, ex_immSel, ex_opA, ex_nextPc,
      output ex_alu, ex_aluSel, ex_rd, ex_illegal,
      output wb_valid, wb_regWrite, wb_memToReg, wb_rd, hazard_stall
   );
endinterface

// File: rtl/pipe_control_decode.sv
// Pipelined RV32I control decoder: opcode decode, stage chain,
// valid/ready handshake, external stall, flush and load-use interlock.
module pipe_control_decode #(
   parameter int INSTR_W        = 32,
   parameter int PIPE_STAGES    = 3,
   parameter int RF_ADDR_W      = 5,
   parameter int LOAD_USE_STALL = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   pipe_control_decode_if.slave  bus
);

   typedef struct packed {
      logic                 valid;
      logic                 regWrite;
      logic                 branch;
      logic                 opB;
      logic                 store;
      logic                 memToReg;
      logic [2:0]           immSel;
      logic [1:0]           opA;
      logic [1:0]           nextPc;
      logic [2:0]           alu;
      logic [3:0]           aluSel;
      logic [RF_ADDR_W-1:0] rd;
      logic                 illegal;
   } ctrl_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_L   = 7'b0000011;
   localparam logic [6:0] OP_S   = 7'b0100011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_J   = 7'b1101111;
   localparam logic [6:0] OP_JR  = 7'b1100111;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;

   logic [6:0]           opc;
   logic [2:0]           f3;
   logic                 f7b5;
   logic [RF_ADDR_W-1:0] rd;
   logic [RF_ADDR_W-1:0] rs1;
   logic [RF_ADDR_W-1:0] rs2;
   logic                 use_rs1;
   logic                 use_rs2;
   logic                 ld_hit;
   logic                 xfer;
   logic                 unused_bits;
   ctrl_t                dec;
   ctrl_t                stg_d [PIPE_STAGES];
   ctrl_t                stg_q [PIPE_STAGES];

   assign opc  = bus.instr[6:0];
   assign f3   = bus.instr[14:12];
   assign f7b5 = bus.instr[30];
   assign rd   = bus.instr[7 +: RF_ADDR_W];
   assign rs1  = bus.instr[15 +: RF_ADDR_W];
   assign rs2  = bus.instr[20 +: RF_ADDR_W];
   assign unused_bits = ^{bus.instr[INSTR_W-1:31], bus.instr[29:25]};

   // Decode the incoming word into a control bundle and register-read flags.
   always_comb begin
      dec       = '0;
      dec.valid = 1'b1;
      dec.rd    = rd;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      unique case (1'b1)
         opc == OP_R: begin
            dec.regWrite = 1'b1;
            dec.aluSel   = {f7b5, f3};
            use_rs1      = 1'b1;
            use_rs2      = 1'b1;
         end
         opc == OP_I: begin
            dec.regWrite = 1'b1;
            dec.opB      = 1'b1;
            dec.aluSel   = {(f3 == 3'b101) ? f7b5 : 1'b0, f3};
            use_rs1      = 1'b1;
         end
         opc == OP_L: begin
            dec.regWrite = 1'b1;
            dec.opB      = 1'b1;
            dec.memToReg = 1'b1;
            dec.alu      = f3;
            use_rs1      = 1'b1;
         end
         opc == OP_S: begin
            dec.store  = 1'b1;
            dec.opB    = 1'b1;
            dec.immSel = 3'b001;
            dec.alu    = f3;
            dec.rd     = '0;
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
         end
         opc == OP_B: begin
            dec.branch = 1'b1;
            dec.immSel = 3'b010;
            dec.nextPc = 2'b01;
            dec.alu    = f3;
            dec.rd     = '0;
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
         end
         opc == OP_J: begin
            dec.regWrite = 1'b1;
            dec.opA      = 2'b01;
            dec.immSel   = 3'b100;
            dec.nextPc   = 2'b10;
         end
         opc == OP_JR: begin
            dec.regWrite = 1'b1;
            dec.opB      = 1'b1;
            dec.nextPc   = 2'b11;
            use_rs1      = 1'b1;
         end
         opc == OP_LUI: begin
            dec.regWrite = 1'b1;
            dec.opA      = 2'b10;
            dec.opB      = 1'b1;
            dec.immSel   = 3'b011;
         end
         opc == OP_AUI: begin
            dec.regWrite = 1'b1;
            dec.opA      = 2'b01;
            dec.opB      = 1'b1;
            dec.immSel   = 3'b011;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

   assign ld_hit = stg_q[0].valid && stg_q[0].memToReg &&
                   (stg_q[0].rd != '0) && bus.in_valid && !bus.flush &&
                   ((use_rs1 && (rs1 == stg_q[0].rd)) ||
                    (use_rs2 && (rs2 == stg_q[0].rd)));

   assign bus.hazard_stall = (LOAD_USE_STALL != 0) && ld_hit;
   assign bus.in_ready     = !bus.stall_ext && !bus.hazard_stall;
   assign xfer             = bus.in_valid && bus.in_ready;

   // Next state of the chain: shift when free-running, hold under stall.
   always_comb begin
      stg_d = stg_q;
      if (!bus.stall_ext) begin
         stg_d[0] = (xfer && !bus.flush) ? dec : '0;
         for (int i = 1; i < PIPE_STAGES; i++) begin
            stg_d[i] = stg_q[i-1];
         end
      end else if (bus.flush) begin
         stg_d[0] = '0;
      end
   end

   // Stage registers, all cleared to bubbles on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < PIPE_STAGES; i++) begin
            stg_q[i] <= '0;
         end
      end else begin
         stg_q <= stg_d;
      end
   end

   assign bus.ex_valid    = stg_q[0].valid;
   assign bus.ex_regWrite = stg_q[0].regWrite;
   assign bus.ex_branch   = stg_q[0].branch;
   assign bus.ex_opB      = stg_q[0].opB;
   assign bus.ex_store    = stg_q[0].store;
   assign bus.ex_memToReg = stg_q[0].memToReg;
   assign bus.ex_immSel   = stg_q[0].immSel;
   assign bus.ex_opA      = stg_q[0].opA;
   assign bus.ex_nextPc   = stg_q[0].nextPc;
   assign bus.ex_alu      = stg_q[0].alu;
   assign bus.ex_aluSel   = stg_q[0].aluSel;
   assign bus.ex_rd       = stg_q[0].rd;
   assign bus.ex_illegal  = stg_q[0].illegal;
   assign bus.wb_valid    = stg_q[PIPE_STAGES-1].valid;
   assign bus.wb_regWrite = stg_q[PIPE_STAGES-1].regWrite;
   assign bus.wb_memToReg = stg_q[PIPE_STAGES-1].memToReg;
   assign bus.wb_rd       = stg_q[PIPE_STAGES-1].rd;

endmodule

// File: tb/tb_pipe_control_decode.sv
// Scoreboard bench for pipe_control_decode: four instances
// (depths 3, 1, 4 and one without interlock) share one random stream.
module tb_pipe_control_decode;

   typedef struct packed {
      logic       valid;
      logic       rw;
      logic       br;
      logic       opb;
      logic       st;
      logic       m2r;
      logic [2:0] imm;
      logic [1:0] opa;
      logic [1:0] npc;
      logic [2:0] alu;
      logic [3:0] als;
      logic [4:0] rd;
      logic       ill;
   } ctrl_t;

   localparam int PSL [4] = '{3, 1, 4, 3};
   localparam int LUL [4] = '{1, 1, 1, 0};
   localparam logic [6:0] OPS [11] = '{
      7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
      7'h67, 7'h37, 7'h17, 7'h7F, 7'h0B};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        stall_ext = 1'b0;
   logic        flush = 1'b0;

   ctrl_t       exb [4];
   logic [3:0]  rdy;
   logic [3:0]  haz;
   logic [3:0]  exv;
   logic [3:0]  wbv;
   logic [3:0]  wbw;
   logic [3:0]  wbm;
   logic [4:0]  wbr [4];

   ctrl_t       s0 = '0;
   ctrl_t       wbq [3][$];
   logic        adv = 1'b0;
   int          nchk = 0;
   int          npass = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : gi
      pipe_control_decode_if #(.INSTR_W(32), .RF_ADDR_W(5)) b ();
      assign b.in_valid  = in_valid;
      assign b.instr     = instr;
      assign b.stall_ext = stall_ext;
      assign b.flush     = flush;
      pipe_control_decode #(
         .INSTR_W(32), .PIPE_STAGES(PSL[g]),
         .RF_ADDR_W(5), .LOAD_USE_STALL(LUL[g])
      ) dut (
         .clk(clk), .rst(rst), .bus(b)
      );
      assign exb[g] = {b.ex_valid, b.ex_regWrite, b.ex_branch, b.ex_opB,
                       b.ex_store, b.ex_memToReg, b.ex_immSel, b.ex_opA,
                       b.ex_nextPc, b.ex_alu, b.ex_aluSel, b.ex_rd,
                       b.ex_illegal};
      assign rdy[g] = b.in_ready;
      assign haz[g] = b.hazard_stall;
      assign exv[g] = b.ex_valid;
      assign wbv[g] = b.wb_valid;
      assign wbw[g] = b.wb_regWrite;
      assign wbm[g] = b.wb_memToReg;
      assign wbr[g] = b.wb_rd;
   end

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      nchk++;
      if (a === e) npass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
   endtask

   // Reference decode straight from the instruction-class table.
   function automatic ctrl_t ref_dec(input logic [31:0] i);
      ctrl_t      c;
      logic [2:0] f3;
      c = '0;
      f3 = i[14:12];
      c.valid = 1'b1;
      c.rd = i[11:7];
      case (i[6:0])
         7'h33: begin c.rw = 1; c.als = {i[30], f3}; end
         7'h13: begin
            c.rw = 1; c.opb = 1;
            c.als = {(f3 == 3'd5) ? i[30] : 1'b0, f3};
         end
         7'h03: begin c.rw = 1; c.opb = 1; c.m2r = 1; c.alu = f3; end
         7'h23: begin
            c.st = 1; c.opb = 1; c.imm = 3'd1; c.alu = f3; c.rd = 0;
         end
         7'h63: begin
            c.br = 1; c.imm = 3'd2; c.npc = 2'd1; c.alu = f3; c.rd = 0;
         end
         7'h6F: begin c.rw = 1; c.opa = 2'd1; c.imm = 3'd4; c.npc = 2'd2; end
         7'h67: begin c.rw = 1; c.opb = 1; c.npc = 2'd3; end
         7'h37: begin c.rw = 1; c.opa = 2'd2; c.opb = 1; c.imm = 3'd3; end
         7'h17: begin c.rw = 1; c.opa = 2'd1; c.opb = 1; c.imm = 3'd3; end
         default: c.ill = 1;
      endcase
      return c;
   endfunction

   function automatic logic reads(input logic [31:0] i, input logic [4:0] r);
      logic u1;
      logic u2;
      u1 = i[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
      u2 = i[6:0] inside {7'h33, 7'h23, 7'h63};
      return (u1 && i[19:15] == r) || (u2 && i[24:20] == r);
   endfunction

   // One clock of stimulus: drive, check handshake, update the model.
   task automatic cycle(input logic v, input logic [31:0] ins,
                        input logic st, input logic fl);
      logic  eh;
      logic  er;
      logic  x;
      ctrl_t d;
      in_valid = v;
      instr = ins;
      stall_ext = st;
      flush = fl;
      #1;
      eh = s0.valid && s0.m2r && (s0.rd != 0) && v && !fl && reads(ins, s0.rd);
      er = !st && !eh;
      for (int g = 0; g < 3; g++) begin
         chk("hazard_stall", 32'(haz[g]), 32'(eh));
         chk("in_ready", 32'(rdy[g]), 32'(er));
      end
      chk("nolu_hazard", 32'(haz[3]), 32'd0);
      chk("nolu_ready", 32'(rdy[3]), 32'(!st));
      x = v && er && !fl;
      d = ref_dec(ins);
      @(posedge clk);
      if (!st) begin
         s0 = x ? d : '0;
         if (x) for (int g = 0; g < 3; g++) wbq[g].push_back(d);
      end else if (fl) begin
         if (s0.valid) begin
            void'(wbq[0].pop_back());
            void'(wbq[2].pop_back());
         end
         s0 = '0;
      end
      #1;
      for (int g = 0; g < 3; g++) chk("ex_bundle", 32'(exb[g]), 32'(s0));
   endtask

   task automatic do_reset();
      in_valid = 0;
      stall_ext = 0;
      flush = 0;
      #2 rst = 1'b0;
      #1;
      for (int g = 0; g < 4; g++) begin
         chk("rst_ex_valid", 32'(exv[g]), 32'd0);
         chk("rst_wb_valid", 32'(wbv[g]), 32'd0);
      end
      for (int g = 0; g < 3; g++) wbq[g].delete();
      s0 = '0;
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [31:0] w;
      w = $urandom;
      w[6:0] = OPS[$urandom_range(0, 10)];
      w[11:7] = 5'($urandom_range(0, 3));
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      return w;
   endfunction

   always @(posedge clk) adv <= !stall_ext;

   // Monitors: every new WB entry must match the oldest expected one.
   for (genvar g = 0; g < 3; g++) begin : mon
      always @(negedge clk) begin
         ctrl_t e;
         if (rst && adv && wbv[g]) begin
            if (wbq[g].size() == 0) begin
               chk("wb_unexpected", 32'(wbv[g]), 32'd0);
            end else begin
               e = wbq[g].pop_front();
               chk("wb_entry", {25'd0, wbw[g], wbm[g], wbr[g]},
                   {25'd0, e.rw, e.m2r, e.rd});
            end
         end
      end
   end

   initial begin
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      for (int g = 0; g < 4; g++) begin
         chk("reset_ex_valid", 32'(exv[g]), 32'd0);
         chk("reset_wb_valid", 32'(wbv[g]), 32'd0);
         chk("reset_in_ready", 32'(rdy[g]), 32'd1);
         chk("reset_hazard", 32'(haz[g]), 32'd0);
      end
      cycle(1, 32'h003100B3, 0, 0);
      chk("add_ex", {exb[0].valid, exb[0].rw, exb[0].als, exb[0].rd},
          {1'b1, 1'b1, 4'b0000, 5'd1});
      cycle(1, 32'h403100B3, 0, 0);
      chk("sub_alusel", 32'(exb[0].als), 32'b1000);
      cycle(1, 32'h4030D093, 0, 0);
      chk("srai_ex", {exb[0].opb, exb[0].als}, {1'b1, 4'b1101});
      chk("add_wb", {wbv[0], wbr[0]}, {1'b1, 5'd1});
      cycle(1, 32'h0000007F, 0, 0);
      chk("illegal_ex", {exb[0].ill, exb[0].rw}, {1'b1, 1'b0});
      cycle(1, 32'h0000A283, 0, 0);
      cycle(1, 32'h00128333, 0, 0);
      chk("loaduse_bubble", 32'(exv[0]), 32'd0);
      chk("nolu_no_bubble", {exv[3], exb[3].rd}, {1'b1, 5'd6});
      cycle(1, 32'h00128333, 0, 0);
      chk("loaduse_after", {exv[0], exb[0].rd}, {1'b1, 5'd6});
      repeat (3) cycle(1, 32'h003100B3, 1, 0);
      cycle(1, 32'h00208063, 0, 1);
      chk("flush_beq", 32'(exv[0]), 32'd0);
      cycle(1, 32'h003100B3, 0, 0);
      cycle(1, 32'h00208063, 1, 1);
      chk("flush_stall", 32'(exv[0]), 32'd0);
      cycle(1, 32'h003100B3, 0, 0);
      cycle(1, 32'h0000A283, 0, 0);
      cycle(1, 32'h00128333, 0, 0);
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         cycle($urandom_range(0, 3) != 0, rnd_instr(),
               $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      end
      repeat (6) cycle(0, 32'h0, 0, 0);
      for (int g = 0; g < 3; g++) chk("wb_drained", wbq[g].size(), 32'd0);
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/pipe_control_decode.md
Name: pipe_control_decode

Overview:
- Pipelined successor to the single-cycle control decoder of the RV32I core.
- Takes a raw 32-bit instruction word instead of one-hot type strobes and decodes the opcode internally.
- Registers the control bundle through a parametrised chain of pipeline stages (ID/EX … MEM/WB).
- Adds a valid/ready handshake, external stall, branch flush and load-use interlock.

Parameters:
- INSTR_W, 32, instruction width; bits [6:0] opcode, [11:7] rd, [14:12] funct3, [19:15] rs1, [24:20] rs2, [30] funct7b5.
- PIPE_STAGES, 3, number of control pipeline registers; legal range 1..4. Stage 0 = ID/EX, stage PIPE_STAGES-1 = WB.
- RF_ADDR_W, 5, register-file address width.
- LOAD_USE_STALL, 1, 1 enables the load-use interlock; 0 ties hazard_stall to 0.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  instr is valid.
- in_ready  out  1  decoder accepts instr this cycle.
- instr  in  INSTR_W  instruction word.
- stall_ext  in  1  downstream backpressure; the whole chain holds.
- flush  in  1  kill stage 0 and the incoming instruction (taken branch/jump).
- ex_valid  out  1  stage-0 entry is valid.
- ex_regWrite, ex_branch, ex_opB, ex_store, ex_memToReg  out  1 each  stage-0 controls.
- ex_immSel  out  3  000 I, 001 S, 010 B, 011 U, 100 J.
- ex_opA  out  2  00 rs1, 01 PC, 10 zero.
- ex_nextPc  out  2  00 PC+4, 01 branch, 10 jal, 11 jalr.
- ex_alu  out  3  funct3 passthrough for L/S/B, else 000.
- ex_aluSel  out  4  ALU operation.
- ex_rd  out  RF_ADDR_W  destination register.
- ex_illegal  out  1  stage-0 entry had an unknown opcode.
- wb_valid, wb_regWrite, wb_memToReg  out  1 each  last-stage controls.
- wb_rd  out  RF_ADDR_W  last-stage destination register.
- hazard_stall  out  1  load-use interlock active.

Behaviour:
Decode (combinational, from instr). Unlisted fields are 0.
- R (0110011): regWrite=1; aluSel={f7b5,funct3}.
- I (0010011): regWrite=1, opB=1; aluSel={funct3==101 ? f7b5 : 0, funct3}.
- L (0000011): regWrite=1, opB=1, memToReg=1; alu=funct3.
- S (0100011): store=1, opB=1, immSel=001; alu=funct3.
- B (1100011): branch=1, immSel=010, nextPc=01; alu=funct3.
- J (1101111): regWrite=1, opA=01, immSel=100, nextPc=10.
- Jr (1100111): regWrite=1, opB=1, nextPc=11.
- lui (0110111): regWrite=1, opA=10, opB=1, immSel=011.
- aui (0010111): regWrite=1, opA=01, opB=1, immSel=011.
- Any other opcode: all controls 0, illegal=1.
- rd is forced to 0 for S and B.

Handshake and pipeline:
- in_ready = !stall_ext && !hazard_stall.
- Transfer occurs when in_valid && in_ready.
- When stall_ext=0, each edge shifts stage i → i+1. Stage 0 loads the decoded bundle on a transfer, otherwise a bubble (valid=0, all controls 0).
- When stall_ext=1, all stages hold. Exception: flush still clears stage 0 to a bubble.
- flush=1: stage 0 becomes a bubble at the edge; the incoming instr is dropped even if in_valid && in_ready. Stages ≥1 are unaffected.
- Latency: an instr accepted at edge k appears on ex_* after edge k, and on wb_* after PIPE_STAGES-1 further non-stalled edges.
- With PIPE_STAGES=1, the wb_* outputs equal the ex_* fields.

Load-use interlock:
- hazard_stall=1 when all of the following hold:
  - LOAD_USE_STALL=1,
  - ex_valid && ex_memToReg,
  - ex_rd != 0,
  - in_valid,
  - the incoming instr reads ex_rd. rs1 is read by R/I/L/S/B/Jr; rs2 is read by R/S/B.
- While hazard_stall=1 and stall_ext=0, a bubble enters stage 0, so the hazard clears after one cycle.
- flush has priority: flush=1 forces hazard_stall=0.

Reset:
- rst low asynchronously clears every stage register: valid=0, all controls 0, rd=0.
- Resulting outputs: in_ready=1 (given stall_ext=0), hazard_stall=0.
- Reset mid-stream discards all in-flight entries.

Test Plan:
- Reset then R add (0x003100B3): ex_valid=1, regWrite=1, aluSel=0000, rd=1 after 1 edge; wb_valid=1, wb_rd=1 after 3 edges.
- sub 0x403100B3 → aluSel=1000. srai 0x4030D093 → opB=1, aluSel=1101. Opcode 0x7F → ex_illegal=1, regWrite=0.
- lw x5 (0x0000A283) then add x6,x5,x1 (0x00128333): hazard_stall=1 and in_ready=0 for 1 cycle, one bubble between them; with LOAD_USE_STALL=0 there is no bubble.
- stall_ext=1 for 3 cycles mid-stream: all ex_*/wb_* outputs hold; in_ready=0.
- flush together with a valid beq: stage 0 becomes a bubble and the beq is dropped; flush during stall_ext clears stage 0 only.
- Drive rst low with 3 instructions in flight: all valid=0 immediately (asynchronous), no wb_regWrite pulse after release; repeat the test with PIPE_STAGES=1 and 4.
